// File: rtl/softmax_max_sub.sv
// Softmax front end: buffers one row of signed logits while tracking the row maximum,
// then streams saturated (x[i] - max) values in arrival order for the exp stage.
module softmax_max_sub #(
  parameter int unsigned DW     = 32,
  parameter int unsigned RowLen = 128
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 in_valid_i,
  input  logic signed [DW-1:0] qin_i,
  output logic                 in_ready_o,
  output logic                 out_valid_o,
  output logic signed [DW-1:0] qout_o,
  output logic                 out_last_o
);

  localparam int unsigned CntW = (RowLen > 1) ? $clog2(RowLen) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(RowLen - 1);
  localparam logic signed [DW-1:0] MinVal = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [0:0] {StCollect, StDrain} state_e;

  state_e                state_q;
  logic [CntW-1:0]       wr_cnt_q;
  logic [CntW-1:0]       rd_cnt_q;
  logic signed [DW-1:0]  max_q;
  logic signed [DW-1:0]  buf_q [RowLen];

  logic                  accept;
  logic signed [DW-1:0]  rd_data;
  logic signed [DW:0]    diff_wide;
  logic signed [DW-1:0]  diff_sat;

  assign in_ready_o = enable_i & ~rst_i & (state_q == StCollect);
  assign accept     = in_valid_i & in_ready_o;
  assign rd_data    = buf_q[rd_cnt_q];

  // Every buffered element is <= max, so only negative overflow of the wide difference can occur.
  always_comb begin
    diff_wide = {rd_data[DW-1], rd_data} - {max_q[DW-1], max_q};
    if (diff_wide[DW] != diff_wide[DW-1]) begin
      diff_sat = MinVal;
    end else begin
      diff_sat = diff_wide[DW-1:0];
    end
  end

  // Row storage carries no reset; stale contents are always overwritten before being read.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      buf_q[wr_cnt_q] <= qin_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StCollect;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      max_q       <= MinVal;
      out_valid_o <= 1'b0;
      out_last_o  <= 1'b0;
      qout_o      <= '0;
    end else if (enable_i) begin
      unique case (state_q)
        StCollect: begin
          out_valid_o <= 1'b0;
          out_last_o  <= 1'b0;
          if (in_valid_i) begin
            if (qin_i > max_q) begin
              max_q <= qin_i;
            end
            if (wr_cnt_q == LastIdx) begin
              wr_cnt_q <= '0;
              state_q  <= StDrain;
            end else begin
              wr_cnt_q <= wr_cnt_q + 1'b1;
            end
          end
        end
        StDrain: begin
          qout_o      <= diff_sat;
          out_valid_o <= 1'b1;
          out_last_o  <= (rd_cnt_q == LastIdx);
          if (rd_cnt_q == LastIdx) begin
            rd_cnt_q <= '0;
            max_q    <= MinVal;
            state_q  <= StCollect;
          end else begin
            rd_cnt_q <= rd_cnt_q + 1'b1;
          end
        end
        default: state_q <= StCollect;
      endcase
    end
  end

endmodule
